branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Parametrised hardware sequencer for the fetch and conditional-branch control steps of the RISC datapath (T0..T6).
- Replaces hand-driven control strobes with an FSM.
- Includes the CON flip-flop evaluation for all four branch conditions (zr/nz/pl/mi), memory wait states, opcode checking and a single-step debug mode.
- Sits between the future top-level control unit and DataPath; drives DataPath strobes directly.

Parameters:
DATA_WIDTH, 32, width of bus and IR
OPC_HI, 31, MSB of opcode field (opcode is 5 bits, OPC_HI..OPC_HI-4)
C2_LO, 19, LSB of 2-bit condition field C2 in IR
BR_OPCODE, 5'b10010, opcode value identifying a branch instruction
USE_MEM_READY, 1, 1: T1 waits for mem_ready; 0: T1 lasts exactly one cycle

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous, active-low reset
start  in  1  begin one fetch+branch sequence (sampled in IDLE only)
step_en  in  1  1 = single-step mode
step  in  1  in step mode, FSM advances one state per cycle with step=1
ir  in  DATA_WIDTH  current IR contents from DataPath
bus  in  DATA_WIDTH  datapath bus value (Ra during T3)
mem_ready  in  1  memory read data valid
pc_out, mar_in, z_in, zlo_out, pc_in, mem_read, mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out  out  1 each  DataPath control strobes
alu_code  out  5  ALU operation select
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at sequence end
taken  out  1  one-cycle pulse in T6 when branch taken
illegal  out  1  one-cycle pulse when the fetched opcode is not BR_OPCODE

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, FIN. Moore outputs decoded from the state register, except T6 strobes, which are gated by con_ff.
- Reset (clear=0, asynchronous): state=IDLE, con_ff=0, all strobes/alu_code/done/taken/illegal=0.
- Advance enable adv = ~step_en | step. If adv=0, state and con_ff hold; outputs stay those of the current state.
- IDLE: start=1 & adv -> T0. start in any other state is ignored.
- T0: pc_out, mar_in, z_in, alu_code=ALU_INC_PC -> T1.
- T1: zlo_out, pc_in, mem_read, mdr_in.
  - USE_MEM_READY=1: stays in T1 while mem_ready=0, then -> T2.
  - pc_in is asserted only on the exit cycle of T1, so PC increments exactly once regardless of wait states.
- T2: mdr_out, ir_in -> T3.
- T3: gra, r_out, con_in.
  - If the opcode field of ir != BR_OPCODE: illegal=1, go to FIN; con_ff unchanged.
  - Otherwise con_ff <= cond(C2, bus). C2 00: bus==0; 01: bus!=0; 10: bus[MSB]==0; 11: bus[MSB]==1.
  - Evaluate ir in T3, after the T2 load, not in T2.
- T4: pc_out, y_in -> T5.
- T5: c_out, z_in, alu_code=ALU_ADD -> T6.
- T6: if con_ff, zlo_out, pc_in and taken=1 -> FIN.
- FIN: done=1 -> IDLE.
- Latency, no wait states, step_en=0: start sampled at edge k, done high during cycle k+8. Each mem_ready wait cycle adds one.
- clear asserted mid-sequence aborts immediately; no strobes persist. After release the FSM starts in IDLE.
- step_en toggled mid-sequence takes effect on the next edge.

Decomposition:
- Shared package branch_seq_pkg holds:
  - state enum
  - ALU_INC_PC=5'b11111, ALU_ADD=5'b00011
  - C2 encodings C_ZR, C_NZ, C_PL, C_MI
- One sub-module, con_ff_logic: combinational condition decode plus the con_ff register with load enable. It is reused later by the full control unit.

Test Plan:
- R1=15 on bus, C2=01 (brnz), PC=342, C=+5 -> taken pulses in T6; pc_in asserted in T1 and T6; done at cycle 8.
- bus=0, C2=01 -> con_ff=0; no pc_in/zlo_out in T6; taken=0; done still pulses.
- C2=11 with bus=0x8000_0000 -> taken. C2=10 with the same bus -> not taken. C2=00 with bus=0 -> taken.
- mem_ready low for 3 cycles in T1 -> mem_read held 4 cycles; pc_in high only on the final T1 cycle; done at cycle 11.
- clear pulled low during T4 -> all strobes 0 asynchronously; busy=0. Next start runs a full clean sequence.
- Opcode != BR_OPCODE -> illegal pulse in T3, FIN next cycle; no T4..T6 strobes. step_en=1 with a step every 3rd cycle -> same state order, each state held 3 cycles.

Source files
------------

// File: rtl/branch_seq_pkg.sv
// Shared types and constants for the fetch/branch sequencer and its con_ff logic.
package branch_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_FIN
  } state_e;

  typedef enum logic [1:0] {
    C_ZR = 2'b00,
    C_NZ = 2'b01,
    C_PL = 2'b10,
    C_MI = 2'b11
  } cond_e;

  localparam logic [4:0] ALU_INC_PC = 5'b11111;
  localparam logic [4:0] ALU_ADD    = 5'b00011;

  typedef struct packed {
    logic       pc_out;
    logic       mar_in;
    logic       z_in;
    logic       zlo_out;
    logic       pc_in;
    logic       mem_read;
    logic       mdr_in;
    logic       mdr_out;
    logic       ir_in;
    logic       gra;
    logic       r_out;
    logic       con_in;
    logic       y_in;
    logic       c_out;
    logic [4:0] alu_code;
  } ctrl_t;

endpackage

// File: rtl/con_ff_logic.sv
// Branch condition decode (zr/nz/pl/mi on the bus value) and the CON flip-flop.
module con_ff_logic
  import branch_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  load_i,
  input  cond_e                 c2_i,
  input  logic [DATA_WIDTH-1:0] bus_i,
  output logic                  con_o
);

  logic cond_met;
  logic con_q;

  always_comb begin
    cond_met = 1'b0;
    unique case (c2_i)
      C_ZR: cond_met = (bus_i == '0);
      C_NZ: cond_met = (bus_i != '0);
      C_PL: cond_met = ~bus_i[DATA_WIDTH-1];
      C_MI: cond_met = bus_i[DATA_WIDTH-1];
      default: cond_met = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)      con_q <= 1'b0;
    else if (load_i) con_q <= cond_met;
  end

  assign con_o = con_q;

endmodule

// File: rtl/branch_sequencer.sv
// Fetch + conditional-branch control FSM (T0..T6) driving DataPath strobes,
// with memory wait states, opcode checking and single-step support.
module branch_sequencer
  import branch_seq_pkg::*;
#(
  parameter int         DATA_WIDTH    = 32,
  parameter int         OPC_HI        = 31,
  parameter int         C2_LO         = 19,
  parameter logic [4:0] BR_OPCODE     = 5'b10010,
  parameter bit         USE_MEM_READY = 1'b1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  step_en,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic [DATA_WIDTH-1:0] bus,
  input  logic                  mem_ready,
  output logic                  pc_out,
  output logic                  mar_in,
  output logic                  z_in,
  output logic                  zlo_out,
  output logic                  pc_in,
  output logic                  mem_read,
  output logic                  mdr_in,
  output logic                  mdr_out,
  output logic                  ir_in,
  output logic                  gra,
  output logic                  r_out,
  output logic                  con_in,
  output logic                  y_in,
  output logic                  c_out,
  output logic [4:0]            alu_code,
  output logic                  busy,
  output logic                  done,
  output logic                  taken,
  output logic                  illegal
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   adv, mem_ok, is_branch, con_load, con_q;
  logic   ir_unused;

  assign adv       = ~step_en | step;
  assign mem_ok    = (USE_MEM_READY == 1'b0) | mem_ready;
  assign is_branch = (ir[OPC_HI -: 5] == BR_OPCODE);
  assign ir_unused = ^ir;

  con_ff_logic #(.DATA_WIDTH(DATA_WIDTH)) u_con (
    .clock  (clock),
    .clear  (clear),
    .load_i (con_load),
    .c2_i   (cond_e'(ir[C2_LO +: 2])),
    .bus_i  (bus),
    .con_o  (con_q)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d  = state_q;
    ctrl     = '0;
    con_load = 1'b0;
    done     = 1'b0;
    taken    = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start && adv) state_d = S_T0;
      S_T0: begin
        ctrl.pc_out   = 1'b1;
        ctrl.mar_in   = 1'b1;
        ctrl.z_in     = 1'b1;
        ctrl.alu_code = ALU_INC_PC;
        if (adv) state_d = S_T1;
      end
      S_T1: begin
        ctrl.zlo_out  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.mdr_in   = 1'b1;
        // PC loads only on the cycle that leaves T1, so wait states never double-increment it.
        if (adv && mem_ok) begin
          ctrl.pc_in = 1'b1;
          state_d    = S_T2;
        end
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        if (adv) state_d = S_T3;
      end
      S_T3: begin
        ctrl.gra    = 1'b1;
        ctrl.r_out  = 1'b1;
        ctrl.con_in = 1'b1;
        illegal     = ~is_branch;
        con_load    = adv & is_branch;
        if (adv) state_d = is_branch ? S_T4 : S_FIN;
      end
      S_T4: begin
        ctrl.pc_out = 1'b1;
        ctrl.y_in   = 1'b1;
        if (adv) state_d = S_T5;
      end
      S_T5: begin
        ctrl.c_out    = 1'b1;
        ctrl.z_in     = 1'b1;
        ctrl.alu_code = ALU_ADD;
        if (adv) state_d = S_T6;
      end
      S_T6: begin
        ctrl.zlo_out = con_q;
        ctrl.pc_in   = con_q;
        taken        = con_q;
        if (adv) state_d = S_FIN;
      end
      S_FIN: begin
        done = 1'b1;
        if (adv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign pc_out   = ctrl.pc_out;
  assign mar_in   = ctrl.mar_in;
  assign z_in     = ctrl.z_in;
  assign zlo_out  = ctrl.zlo_out;
  assign pc_in    = ctrl.pc_in;
  assign mem_read = ctrl.mem_read;
  assign mdr_in   = ctrl.mdr_in;
  assign mdr_out  = ctrl.mdr_out;
  assign ir_in    = ctrl.ir_in;
  assign gra      = ctrl.gra;
  assign r_out    = ctrl.r_out;
  assign con_in   = ctrl.con_in;
  assign y_in     = ctrl.y_in;
  assign c_out    = ctrl.c_out;
  assign alu_code = ctrl.alu_code;

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench: each sequence pushes its expected strobe profile; a monitor
// accumulates per-sequence strobe counts and compares them when done rises.
module tb_branch_sequencer;

  logic        clock = 1'b0;
  logic        clear, start, step_en, step, mem_ready;
  logic [31:0] ir, bus;
  logic        pc_out, mar_in, z_in, zlo_out, pc_in, mem_read, mdr_in, mdr_out;
  logic        ir_in, gra, r_out, con_in, y_in, c_out;
  logic [4:0]  alu_code;
  logic        busy, done, taken, illegal;

  typedef struct {
    string nm;
    int lat, pc_n, zlo_n, mr_n, y_n, tk_n, ill_n, inc_n, add_n;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  branch_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .step_en(step_en), .step(step),
    .ir(ir), .bus(bus), .mem_ready(mem_ready),
    .pc_out(pc_out), .mar_in(mar_in), .z_in(z_in), .zlo_out(zlo_out), .pc_in(pc_in),
    .mem_read(mem_read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .gra(gra),
    .r_out(r_out), .con_in(con_in), .y_in(y_in), .c_out(c_out), .alu_code(alu_code),
    .busy(busy), .done(done), .taken(taken), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [1:0] c2);
    return {opc, 4'd2, 2'b00, c2, 19'd5};
  endfunction

  function automatic exp_t exp_std(input string nm, input int tk, input int w);
    exp_t e;
    e.nm = nm;   e.lat = 8 + w;      e.pc_n = 1 + tk;  e.zlo_n = 1 + w + tk;
    e.mr_n = 1 + w; e.y_n = 1;       e.tk_n = tk;      e.ill_n = 0;
    e.inc_n = 1; e.add_n = 1;
    return e;
  endfunction

  function automatic logic [19:0] all_outs();
    return {pc_out, mar_in, z_in, zlo_out, pc_in, mem_read, mdr_in, mdr_out, ir_in,
            gra, r_out, con_in, y_in, c_out, done, taken, illegal, busy, |alu_code, 1'b0};
  endfunction

  // Monitor: accumulate strobe activity while busy; compare on rising done.
  initial begin
    exp_t e;
    int lat, pc_n, zlo_n, mr_n, y_n, tk_n, ill_n, inc_n, add_n;
    bit done_prev;
    done_prev = 1'b0;
    lat = 0; pc_n = 0; zlo_n = 0; mr_n = 0; y_n = 0; tk_n = 0; ill_n = 0; inc_n = 0; add_n = 0;
    forever begin
      @(negedge clock);
      if (!clear || !busy) begin
        lat = 0; pc_n = 0; zlo_n = 0; mr_n = 0; y_n = 0; tk_n = 0; ill_n = 0; inc_n = 0; add_n = 0;
      end else begin
        lat++;
        pc_n  += int'(pc_in);   zlo_n += int'(zlo_out); mr_n  += int'(mem_read);
        y_n   += int'(y_in);    tk_n  += int'(taken);   ill_n += int'(illegal);
        if (alu_code == 5'b11111) inc_n++;
        if (alu_code == 5'b00011) add_n++;
      end
      if (clear && done && !done_prev) begin
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          check({e.nm, ".latency"},  lat,   e.lat);
          check({e.nm, ".pc_in"},    pc_n,  e.pc_n);
          check({e.nm, ".zlo_out"},  zlo_n, e.zlo_n);
          check({e.nm, ".mem_read"}, mr_n,  e.mr_n);
          check({e.nm, ".y_in"},     y_n,   e.y_n);
          check({e.nm, ".taken"},    tk_n,  e.tk_n);
          check({e.nm, ".illegal"},  ill_n, e.ill_n);
          check({e.nm, ".alu_inc"},  inc_n, e.inc_n);
          check({e.nm, ".alu_add"},  add_n, e.add_n);
        end
        lat = 0; pc_n = 0; zlo_n = 0; mr_n = 0; y_n = 0; tk_n = 0; ill_n = 0; inc_n = 0; add_n = 0;
      end
      done_prev = done;
    end
  end

  task automatic run_seq(input exp_t e, input logic [31:0] ir_v, input logic [31:0] bus_v,
                         input int waits, input bit step_mode);
    int c, budget;
    bit started;
    q.push_back(e);
    @(posedge clock); #1;
    ir = ir_v; bus = bus_v; step_en = step_mode; start = 1'b1; step = 1'b1;
    mem_ready = (waits == 0);
    c = 0; budget = 0; started = 1'b0;
    while (budget < 400) begin
      @(posedge clock); #1;
      budget++; c++;
      if (busy) begin start = 1'b0; started = 1'b1; end
      step = (c % 3 == 0);
      if (mem_read && waits > 0) begin waits--; mem_ready = 1'b0; end
      else mem_ready = 1'b1;
      if (started && !busy) break;
    end
    check({e.nm, ".completes"}, int'(budget < 400), 1);
    start = 1'b0; step_en = 1'b0; step = 1'b0;
  endtask

  task automatic abort_in_t4();
    int budget;
    @(posedge clock); #1;
    ir = mk_ir(5'b10010, 2'b01); bus = 32'd15; mem_ready = 1'b1; start = 1'b1;
    budget = 0;
    while (!y_in && budget < 50) begin
      @(posedge clock); #1;
      budget++;
      if (busy) start = 1'b0;
    end
    check("abort.reached_t4", int'(y_in), 1);
    #2 clear = 1'b0;
    #1;
    check("abort.outputs_zero", int'(all_outs()), 0);
    check("abort.busy", int'(busy), 0);
    @(posedge clock); #1;
    check("abort.held_idle", int'(busy), 0);
    clear = 1'b1;
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; step_en = 1'b0; step = 1'b0; mem_ready = 1'b1;
    ir = '0; bus = '0;
    #2;
    check("reset.outputs_zero", int'(all_outs()), 0);
    check("reset.alu_code", int'(alu_code), 0);
    repeat (2) @(posedge clock);
    #1 clear = 1'b1;
    @(posedge clock); #1;
    check("idle.busy", int'(busy), 0);

    run_seq(exp_std("brnz_taken", 1, 0),     mk_ir(5'b10010, 2'b01), 32'd15,        0, 1'b0);
    run_seq(exp_std("brnz_not_taken", 0, 0), mk_ir(5'b10010, 2'b01), 32'd0,         0, 1'b0);
    run_seq(exp_std("brmi_taken", 1, 0),     mk_ir(5'b10010, 2'b11), 32'h8000_0000, 0, 1'b0);
    run_seq(exp_std("brpl_not_taken", 0, 0), mk_ir(5'b10010, 2'b10), 32'h8000_0000, 0, 1'b0);
    run_seq(exp_std("brzr_taken", 1, 0),     mk_ir(5'b10010, 2'b00), 32'd0,         0, 1'b0);
    run_seq(exp_std("wait3", 1, 3),          mk_ir(5'b10010, 2'b01), 32'd15,        3, 1'b0);

    abort_in_t4();
    run_seq(exp_std("after_abort", 1, 0),    mk_ir(5'b10010, 2'b01), 32'd15,        0, 1'b0);

    begin
      exp_t e;
      e.nm = "illegal_op"; e.lat = 5; e.pc_n = 1; e.zlo_n = 1; e.mr_n = 1; e.y_n = 0;
      e.tk_n = 0; e.ill_n = 1; e.inc_n = 1; e.add_n = 0;
      run_seq(e, mk_ir(5'b00001, 2'b01), 32'd15, 0, 1'b0);
      e.nm = "step_mode"; e.lat = 22; e.pc_n = 4; e.zlo_n = 6; e.mr_n = 3; e.y_n = 3;
      e.tk_n = 3; e.ill_n = 0; e.inc_n = 3; e.add_n = 3;
      run_seq(e, mk_ir(5'b10010, 2'b01), 32'd15, 0, 1'b1);
    end

    repeat (3) @(posedge clock);
    check("scoreboard.drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
